// File: rtl/twofish_pkg.sv
// rtl/twofish_pkg.sv - shared types, q-select table and key-count clamp for the h engine
package twofish_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic Q_SEL_Q0 = 1'b0;
  localparam logic Q_SEL_Q1 = 1'b1;

  // Indexed [stage][byte]; each row is written byte3..byte0.
  localparam logic [4:0][3:0] Q_SEL_TABLE = {
    {Q_SEL_Q1, Q_SEL_Q0, Q_SEL_Q0, Q_SEL_Q1},
    {Q_SEL_Q0, Q_SEL_Q0, Q_SEL_Q1, Q_SEL_Q1},
    {Q_SEL_Q1, Q_SEL_Q0, Q_SEL_Q1, Q_SEL_Q0},
    {Q_SEL_Q1, Q_SEL_Q1, Q_SEL_Q0, Q_SEL_Q0},
    {Q_SEL_Q0, Q_SEL_Q1, Q_SEL_Q0, Q_SEL_Q1}
  };

  function automatic logic [2:0] clamp_k(input logic [2:0] k, input logic [2:0] k_max);
    if (k < 3'd2) return 3'd2;
    if (k > k_max) return k_max;
    return k;
  endfunction

endpackage

// File: rtl/twofish_q_lane.sv
// rtl/twofish_q_lane.sv - one byte lane: q0/q1 permutation, select mux and key-byte XOR
module twofish_q_lane
  import twofish_pkg::*;
(
  input  logic [7:0] x,
  input  logic       sel,
  input  logic [7:0] key,
  output logic [7:0] y
);

  // Nibble tables packed with entry 0 in the low nibble.
  localparam logic [63:0] Q0_T0 = 64'h4ACE_95B0_23F6_D718;
  localparam logic [63:0] Q0_T1 = 64'hD907_6A4F_5321_8BCE;
  localparam logic [63:0] Q0_T2 = 64'h1742_3F8C_09D6_E5AB;
  localparam logic [63:0] Q0_T3 = 64'hAC58_03B9_E621_4F7D;
  localparam logic [63:0] Q1_T0 = 64'h5CA0_4913_E67F_DB82;
  localparam logic [63:0] Q1_T1 = 64'h809F_5AD6_73C4_B2E1;
  localparam logic [63:0] Q1_T2 = 64'hF3B2_8DE0_A961_57C4;
  localparam logic [63:0] Q1_T3 = 64'hA802_F746_ED3C_159B;

  function automatic logic [3:0] ror4(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  function automatic logic [7:0] q_perm(input logic [7:0] v, input logic [63:0] t0,
                                        input logic [63:0] t1, input logic [63:0] t2,
                                        input logic [63:0] t3);
    logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3;
    a0 = v[7:4];
    b0 = v[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ ror4(b0) ^ {a0[0], 3'b000};
    a2 = t0[{a1, 2'b00} +: 4];
    b2 = t1[{b1, 2'b00} +: 4];
    a3 = a2 ^ b2;
    b3 = a2 ^ ror4(b2) ^ {a2[0], 3'b000};
    return {t3[{b3, 2'b00} +: 4], t2[{a3, 2'b00} +: 4]};
  endfunction

  logic [7:0] q0_y;
  logic [7:0] q1_y;

  assign q0_y = q_perm(x, Q0_T0, Q0_T1, Q0_T2, Q0_T3);
  assign q1_y = q_perm(x, Q1_T0, Q1_T1, Q1_T2, Q1_T3);
  assign y    = ((sel == Q_SEL_Q0) ? q0_y : q1_y) ^ key;

endmodule

// File: rtl/twofish_h_engine.sv
// rtl/twofish_h_engine.sv - iterative keyed h-function, one q layer per clock, k = 2..K_MAX
module twofish_h_engine
  import twofish_pkg::*;
#(
  parameter int K_MAX         = 4,
  parameter bit OUT_BYTE_SWAP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_x,
  input  logic [32*K_MAX-1:0]  in_s,
  input  logic [2:0]           in_k,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_y
);

  state_t               state_q, state_d;
  logic [31:0]          work_q, work_d;
  logic [32*K_MAX-1:0]  key_q, key_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [31:0]          out_y_q, out_y_d;

  logic [3:0]           stage_sel;
  logic [31:0]          key_word;
  logic [31:0]          stage_y;
  logic [31:0]          stage_packed;

  assign stage_sel = Q_SEL_TABLE[cnt_q];

  // Stage c XORs S[c-1]; stage 0 has no key word.
  always_comb begin
    key_word = '0;
    for (int j = 0; j < K_MAX; j++) begin
      if (cnt_q == 3'(j + 1)) key_word = key_q[32*j +: 32];
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_lane
    twofish_q_lane u_lane (
      .x   (work_q[8*b +: 8]),
      .sel (stage_sel[b]),
      .key (key_word[8*b +: 8]),
      .y   (stage_y[8*b +: 8])
    );
  end

  assign stage_packed = OUT_BYTE_SWAP ?
      {stage_y[7:0], stage_y[15:8], stage_y[23:16], stage_y[31:24]} : stage_y;

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    key_d     = key_q;
    cnt_d     = cnt_q;
    out_y_d   = out_y_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        work_d = stage_y;
        if (cnt_q == 3'd0) begin
          out_y_d = stage_packed;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // An accept in DONE overrides the return to IDLE.
    if (in_valid && in_ready) begin
      work_d  = in_x;
      key_d   = in_s;
      cnt_d   = clamp_k(in_k, 3'(K_MAX));
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      out_y_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      out_y_q <= out_y_d;
    end
  end

  assign out_y = out_y_q;

endmodule

// File: tb/tb_twofish_h_engine.sv
// tb/tb_twofish_h_engine.sv - directed and streaming checks of twofish_h_engine
module tb_twofish_h_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [31:0]  in_x;
  logic [127:0] in_s;
  logic [2:0]   in_k;
  logic         out_ready;

  logic         in_ready, out_valid;
  logic [31:0]  out_y;
  logic         in_ready3, out_valid3;
  logic [31:0]  out_y3;
  logic         in_ready_sw, out_valid_sw;
  logic [31:0]  out_y_sw;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0]  HAND_K2_ZERO    = 32'hB31F5BA5;
  localparam logic [31:0]  HAND_K2_ZERO_SW = 32'hA55B1FB3;
  localparam logic [127:0] S_VEC = {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};

  localparam int QT [2][4][16] = '{
    '{'{8,1,7,13,6,15,3,2,0,11,5,9,14,12,10,4},
      '{14,12,11,8,1,2,3,5,15,4,10,6,7,0,9,13},
      '{11,10,5,14,6,13,9,0,12,8,15,3,2,4,7,1},
      '{13,7,15,4,1,2,6,14,9,11,3,0,8,5,12,10}},
    '{'{2,8,11,13,15,7,6,14,3,1,9,4,0,10,12,5},
      '{1,14,2,11,4,12,3,7,6,13,10,5,15,9,0,8},
      '{4,12,7,5,1,6,9,10,0,14,13,8,2,11,3,15},
      '{11,9,5,1,12,3,13,14,6,4,7,15,2,0,8,10}}
  };
  localparam int QSEL [5][4] = '{'{1,0,1,0}, '{0,0,1,1}, '{0,1,0,1}, '{1,1,0,0}, '{1,0,0,1}};

  always #5 clk = ~clk;

  twofish_h_engine #(.K_MAX(4), .OUT_BYTE_SWAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_s(in_s), .in_k(in_k), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y));

  twofish_h_engine #(.K_MAX(3), .OUT_BYTE_SWAP(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3), .in_x(in_x),
    .in_s(in_s[95:0]), .in_k(in_k), .out_valid(out_valid3), .out_ready(out_ready), .out_y(out_y3));

  twofish_h_engine #(.K_MAX(4), .OUT_BYTE_SWAP(1'b0)) dut_sw (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_sw), .in_x(in_x),
    .in_s(in_s), .in_k(in_k), .out_valid(out_valid_sw), .out_ready(out_ready), .out_y(out_y_sw));

  function automatic int q_model(input int sel, input int x);
    int a0, b0, a1, b1, a2, b2, a3, b3;
    a0 = x >> 4;
    b0 = x & 15;
    a1 = a0 ^ b0;
    b1 = a0 ^ (((b0 >> 1) | (b0 << 3)) & 15) ^ ((a0 << 3) & 15);
    a2 = QT[sel][0][a1];
    b2 = QT[sel][1][b1];
    a3 = a2 ^ b2;
    b3 = a2 ^ (((b2 >> 1) | (b2 << 3)) & 15) ^ ((a2 << 3) & 15);
    return (QT[sel][3][b3] << 4) | QT[sel][2][a3];
  endfunction

  function automatic logic [31:0] h_model(input logic [31:0] x, input logic [127:0] s,
                                          input int k, input int kmax, input bit swap);
    logic [7:0] b [4];
    int kk;
    kk = (k < 2) ? 2 : ((k > kmax) ? kmax : k);
    for (int i = 0; i < 4; i++) b[i] = x[8*i +: 8];
    for (int st = kk; st >= 0; st--) begin
      for (int i = 0; i < 4; i++) begin
        b[i] = 8'(q_model(QSEL[st][i], int'(b[i])));
        if (st > 0) b[i] = b[i] ^ s[32*(st-1) + 8*i +: 8];
      end
    end
    return swap ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] x, input logic [127:0] s, input logic [2:0] k,
                       output int lat, output int lat3, output logic [31:0] y,
                       output logic [31:0] y3, output logic [31:0] ysw);
    in_x = x; in_s = s; in_k = k; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_x = 32'hDEADBEEF; in_s = {4{32'hA5A5A5A5}}; in_k = 3'd5;
    lat = -1; lat3 = -1; y = '0; y3 = '0; ysw = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (lat < 0 && out_valid) begin lat = c; y = out_y; ysw = out_y_sw; end
      if (lat3 < 0 && out_valid3) begin lat3 = c; y3 = out_y3; end
    end
  endtask

  task automatic test_reset();
    int lat, lat3;
    logic [31:0] y, y3, ysw;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_x = '0; in_s = '0; in_k = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_y !== 32'h0) begin failures++; $display("FAIL reset_out_y: got %h expected 0", out_y); end
    rst_n = 1'b1;
    tick();
    in_x = 32'h01234567; in_s = S_VEC; in_k = 3'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_y !== 32'h0) begin failures++; $display("FAIL reset_mid_run: got valid=%b y=%h expected valid=0 y=0", out_valid, out_y); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    out_ready = 1'b0; in_x = 32'h0; in_s = '0; in_k = 3'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_done: got valid=%b expected 1", out_valid); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_y !== 32'h0) begin failures++; $display("FAIL reset_mid_done: got valid=%b y=%h expected valid=0 y=0", out_valid, out_y); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    issue(32'h0, '0, 3'd2, lat, lat3, y, y3, ysw);
    checks++; if (y !== HAND_K2_ZERO) begin failures++; $display("FAIL post_reset_result: got %h expected %h", y, HAND_K2_ZERO); end
  endtask

  task automatic test_k2();
    int lat, lat3;
    logic [31:0] y, y3, ysw;
    issue(32'h0, '0, 3'd2, lat, lat3, y, y3, ysw);
    checks++; if (lat != 3) begin failures++; $display("FAIL k2_latency: got %0d expected 3", lat); end
    checks++; if (y !== HAND_K2_ZERO) begin failures++; $display("FAIL k2_hand: got %h expected %h", y, HAND_K2_ZERO); end
    checks++; if (y !== h_model(32'h0, '0, 2, 4, 1'b1)) begin failures++; $display("FAIL k2_model: got %h expected %h", y, h_model(32'h0, '0, 2, 4, 1'b1)); end
    checks++; if (ysw !== HAND_K2_ZERO_SW) begin failures++; $display("FAIL k2_noswap: got %h expected %h", ysw, HAND_K2_ZERO_SW); end
    checks++; if (lat3 != 3 || y3 !== HAND_K2_ZERO) begin failures++; $display("FAIL k2_kmax3: got lat=%0d y=%h expected lat=3 y=%h", lat3, y3, HAND_K2_ZERO); end
  endtask

  task automatic test_k3_k4();
    int lat, lat3;
    logic [31:0] y, y3, ysw, e;
    issue(32'h01234567, S_VEC, 3'd3, lat, lat3, y, y3, ysw);
    e = h_model(32'h01234567, S_VEC, 3, 4, 1'b1);
    checks++; if (lat != 4) begin failures++; $display("FAIL k3_latency: got %0d expected 4", lat); end
    checks++; if (y !== e) begin failures++; $display("FAIL k3_result: got %h expected %h", y, e); end
    checks++; if (lat3 != 4 || y3 !== e) begin failures++; $display("FAIL k3_kmax3: got lat=%0d y=%h expected lat=4 y=%h", lat3, y3, e); end
    issue(32'h01234567, S_VEC, 3'd4, lat, lat3, y, y3, ysw);
    e = h_model(32'h01234567, S_VEC, 4, 4, 1'b1);
    checks++; if (lat != 5) begin failures++; $display("FAIL k4_latency: got %0d expected 5", lat); end
    checks++; if (y !== e) begin failures++; $display("FAIL k4_result: got %h expected %h", y, e); end
    e = h_model(32'h01234567, S_VEC, 4, 4, 1'b0);
    checks++; if (ysw !== e) begin failures++; $display("FAIL k4_noswap: got %h expected %h", ysw, e); end
  endtask

  task automatic test_clamp();
    int lat, lat3;
    logic [31:0] y, y3, ysw, e;
    issue(32'h0, '0, 3'd0, lat, lat3, y, y3, ysw);
    checks++; if (lat != 3 || y !== HAND_K2_ZERO) begin failures++; $display("FAIL clamp_k0: got lat=%0d y=%h expected lat=3 y=%h", lat, y, HAND_K2_ZERO); end
    issue(32'hFEDCBA98, S_VEC, 3'd7, lat, lat3, y, y3, ysw);
    e = h_model(32'hFEDCBA98, S_VEC, 4, 4, 1'b1);
    checks++; if (lat != 5 || y !== e) begin failures++; $display("FAIL clamp_k7_kmax4: got lat=%0d y=%h expected lat=5 y=%h", lat, y, e); end
    e = h_model(32'hFEDCBA98, S_VEC, 3, 4, 1'b1);
    checks++; if (lat3 != 4 || y3 !== e) begin failures++; $display("FAIL clamp_k7_kmax3: got lat=%0d y=%h expected lat=4 y=%h", lat3, y3, e); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] held, e;
    out_ready = 1'b0; in_x = 32'h89ABCDEF; in_s = S_VEC; in_k = 3'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      tick();
      if (out_valid) lat = c;
    end
    held = out_y;
    e = h_model(32'h89ABCDEF, S_VEC, 3, 4, 1'b1);
    checks++; if (lat != 4 || held !== e) begin failures++; $display("FAIL bp_first: got lat=%0d y=%h expected lat=4 y=%h", lat, held, e); end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_y !== e || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: got valid=%b y=%h in_ready=%b expected valid=1 y=%h in_ready=0", out_valid, out_y, in_ready, e);
      end
    end
    in_x = 32'h13579BDF; in_s = S_VEC; in_k = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_accept: got valid=%b expected 0", out_valid); end
    lat = -1;
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      tick();
      if (out_valid) begin lat = c; held = out_y; end
    end
    e = h_model(32'h13579BDF, S_VEC, 2, 4, 1'b1);
    checks++; if (lat != 3 || held !== e) begin failures++; $display("FAIL bp_second: got lat=%0d y=%h expected lat=3 y=%h", lat, held, e); end
    tick(); tick();
  endtask

  task automatic test_stream();
    logic [31:0] exp_q [$];
    logic [31:0] exp_sw_q [$];
    int sent, recv, cyc;
    logic acc_in, acc_out;
    sent = 0; recv = 0; cyc = 0;
    in_valid = 1'b0;
    while (recv < 1000 && cyc < 30000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && sent < 1000) begin
        in_x = $urandom;
        in_s = {$urandom, $urandom, $urandom, $urandom};
        in_k = 3'($urandom_range(0, 7));
        in_valid = 1'b1;
      end
      #1;
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        checks++;
        if (exp_q.size() == 0 || out_y !== exp_q[0] || out_y_sw !== exp_sw_q[0]) begin
          failures++;
          $display("FAIL stream_word %0d: got y=%h y_sw=%h expected y=%h y_sw=%h", recv, out_y, out_y_sw,
                   (exp_q.size() != 0) ? exp_q[0] : 32'h0, (exp_sw_q.size() != 0) ? exp_sw_q[0] : 32'h0);
        end
        if (exp_q.size() != 0) begin void'(exp_q.pop_front()); void'(exp_sw_q.pop_front()); end
        recv++;
      end
      if (acc_in) begin
        exp_q.push_back(h_model(in_x, in_s, int'(in_k), 4, 1'b1));
        exp_sw_q.push_back(h_model(in_x, in_s, int'(in_k), 4, 1'b0));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_in) in_valid = 1'b0;
    end
    checks++;
    if (recv != 1000 || sent != 1000 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stream_count: got sent=%0d recv=%0d pending=%0d expected 1000/1000/0", sent, recv, exp_q.size());
    end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_k2();
    test_k3_k4();
    test_clamp();
    test_back_to_back();
    test_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
